fetch_unit: RTL and testbench

Instruction fetch stage sitting directly downstream of the PC register. Each cycle it issues the current PC as an instruction-memory request and tells the PC register how to update through its existing `is_branch`/`newPC` inputs. The PC register advances by 4 on an accepted request, replays the same address on a stall, and jumps on an execute-stage redirect. Returned instructions are buffered in an in-order FIFO and handed to decode with a valid/ready handshake.

---
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 179 +++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: issues PC as imem requests under a credit limit, buffers responses in order, flushes on redirect.
// Optional FETCH_MISALIGN_CHECK_EN: word-aligns misaligned redirect targets and pulses misalign_err.
module fetch_unit #(
   parameter int FIFO_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] PC,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        is_branch,
   output logic [31:0] newPC,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   input  logic        instr_ready
`ifdef FETCH_MISALIGN_CHECK_EN
   ,output logic       misalign_err
`endif
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   logic [CW-1:0] fifo_cnt, outst, discard;
   logic [AW-1:0] wr_ptr, rd_ptr, pq_wr, pq_rd;
   logic [31:0] data_q [FIFO_DEPTH];
   logic [31:0] addr_q [FIFO_DEPTH];
   logic [31:0] pend_q [FIFO_DEPTH];
   logic [31:0] target;
   logic grant, push, pop;
   // occupied entries plus in-flight requests may never exceed the buffer, so responses always fit
   assign imem_req    = reset && !redirect_valid && (fifo_cnt + outst < CW'(FIFO_DEPTH));
   assign imem_addr   = PC;
   assign grant       = imem_req && imem_gnt;
   assign is_branch   = reset && (redirect_valid || !grant);
   assign newPC       = !reset ? '0 : redirect_valid ? target : PC;
   assign instr_valid = fifo_cnt != '0;
   assign instr       = data_q[rd_ptr];
   assign instr_pc    = addr_q[rd_ptr];
   assign push        = imem_rvalid && discard == '0 && !redirect_valid;
   assign pop         = instr_valid && instr_ready && !redirect_valid;
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fifo_cnt <= '0;
         outst    <= '0;
         discard  <= '0;
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         pq_wr    <= '0;
         pq_rd    <= '0;
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            data_q[i] <= '0;
            addr_q[i] <= '0;
            pend_q[i] <= '0;
         end
      end else begin
         outst <= outst + CW'(grant) - CW'(imem_rvalid);
         if (grant) begin
            pend_q[pq_wr] <= PC;
            pq_wr         <= pq_wr + AW'(1);
         end
         if (imem_rvalid) pq_rd <= pq_rd + AW'(1);
         if (redirect_valid) begin
            discard  <= outst - CW'(imem_rvalid);
            fifo_cnt <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
         end else begin
            if (imem_rvalid && discard != '0) discard <= discard - CW'(1);
            if (push) begin
               data_q[wr_ptr] <= imem_rdata;
               addr_q[wr_ptr] <= pend_q[pq_rd];
               wr_ptr         <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            fifo_cnt <= fifo_cnt + CW'(push) - CW'(pop);
         end
      end
   end
`ifdef FETCH_MISALIGN_CHECK_EN
   logic misaligned;
   assign misaligned = redirect_valid && (redirect_pc[1:0] != 2'b00);
   assign target     = {redirect_pc[31:2], 2'b00};
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) misalign_err <= 1'b0;
      else misalign_err <= misaligned;
   end
`else
   assign target = redirect_pc;
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed bench for fetch_unit with a PC-register model and an in-order memory responder.
module tb_fetch_unit;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [31:0] pc;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic        is_branch;
   logic [31:0] newPC;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt = 1'b0;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_ready = 1'b0;
   logic        hold = 1'b0;
   logic [31:0] mq [$];
   int          checks = 0;
   int          failures = 0;
`ifdef FETCH_MISALIGN_CHECK_EN
   logic        misalign_err;
`endif

   fetch_unit #(.FIFO_DEPTH(2)) dut (
      .clk(clk), .reset(reset), .PC(pc),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
      .is_branch(is_branch), .newPC(newPC),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
      .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
      .instr_valid(instr_valid), .instr(instr), .instr_pc(instr_pc),
      .instr_ready(instr_ready)
`ifdef FETCH_MISALIGN_CHECK_EN
      , .misalign_err(misalign_err)
`endif
   );

   always #5 clk = ~clk;

   // PC register: load newPC on is_branch, else advance by 4
   always @(posedge clk or negedge reset)
      if (!reset) pc <= '0;
      else pc <= is_branch ? newPC : pc + 32'd4;

   // memory returns one granted word per cycle, in order, at least one cycle after grant
   always @(posedge clk or negedge reset) begin
      if (!reset) begin
         mq.delete();
         imem_rvalid <= 1'b0;
         imem_rdata  <= '0;
      end else begin
         if (imem_req && imem_gnt) mq.push_back(imem_addr);
         if (!hold && mq.size() > 0) begin
            imem_rvalid <= 1'b1;
            imem_rdata  <= mq[0] ^ 32'hC0DE_0000;
            mq.pop_front();
         end else imem_rvalid <= 1'b0;
      end
   end

   always @(posedge clk)
      if (reset && imem_rvalid) begin
         checks++;
         assert (dut.outst != '0) else begin
            failures++;
            $error("FAIL rvalid_protocol observed outst=%0d expected nonzero", dut.outst);
         end
      end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_cycle(input string tag, input logic req, input logic [31:0] addr,
                               input logic br, input logic [31:0] npc,
                               input logic iv, input logic [31:0] ipc);
      #1;
      chk({tag, ".req"}, 32'(imem_req), 32'(req));
      if (req) chk({tag, ".addr"}, imem_addr, addr);
      chk({tag, ".is_branch"}, 32'(is_branch), 32'(br));
      if (br) chk({tag, ".newPC"}, newPC, npc);
      chk({tag, ".instr_valid"}, 32'(instr_valid), 32'(iv));
      if (iv) begin
         chk({tag, ".instr_pc"}, instr_pc, ipc);
         chk({tag, ".instr"}, instr, ipc ^ 32'hC0DE_0000);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog timeout checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   initial begin
      tick(); tick();
      expect_cycle("rst", 0, 0, 0, 0, 0, 0);
      chk("rst.newPC", newPC, 32'h0);
      chk("rst.instr", instr, 32'h0);
      chk("rst.instr_pc", instr_pc, 32'h0);
      // streaming, limited to two credits
      reset = 1'b1; imem_gnt = 1'b1; instr_ready = 1'b1;
      expect_cycle("s0", 1, 32'h0, 0, 0, 0, 0);
      tick(); expect_cycle("s1", 1, 32'h4, 0, 0, 0, 0);
      tick(); expect_cycle("s2", 0, 0, 1, 32'h8, 1, 32'h0);
      tick(); expect_cycle("s3", 1, 32'h8, 0, 0, 1, 32'h4);
      tick(); expect_cycle("s4", 1, 32'hC, 0, 0, 0, 0);
      tick(); expect_cycle("s5", 0, 0, 1, 32'h10, 1, 32'h8);
      // grant stall at 0x10
      tick(); imem_gnt = 1'b0; expect_cycle("g0", 1, 32'h10, 1, 32'h10, 1, 32'hC);
      tick(); expect_cycle("g1", 1, 32'h10, 1, 32'h10, 0, 0);
      tick(); expect_cycle("g2", 1, 32'h10, 1, 32'h10, 0, 0);
      tick(); imem_gnt = 1'b1; expect_cycle("g3", 1, 32'h10, 0, 0, 0, 0);
      tick(); expect_cycle("g4", 1, 32'h14, 0, 0, 0, 0);
      // backpressure
      tick(); instr_ready = 1'b0; expect_cycle("b0", 0, 0, 1, 32'h18, 1, 32'h10);
      tick(); expect_cycle("b1", 0, 0, 1, 32'h18, 1, 32'h10);
      chk("b1.fifo_cnt", 32'(dut.fifo_cnt), 32'd2);
      tick(); instr_ready = 1'b1; expect_cycle("b2", 0, 0, 1, 32'h18, 1, 32'h10);
      tick(); hold = 1'b1; expect_cycle("b3", 1, 32'h18, 0, 0, 1, 32'h14);
      // redirect with two outstanding requests
      tick(); expect_cycle("r0", 1, 32'h1C, 0, 0, 0, 0);
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h100; hold = 1'b0;
      expect_cycle("r1", 0, 0, 1, 32'h100, 0, 0);
      chk("r1.outst", 32'(dut.outst), 32'd2);
      tick(); redirect_valid = 1'b0; expect_cycle("r2", 0, 0, 1, 32'h100, 0, 0);
      chk("r2.discard", 32'(dut.discard), 32'd2);
      tick(); expect_cycle("r3", 1, 32'h100, 0, 0, 0, 0);
      tick(); expect_cycle("r4", 1, 32'h104, 0, 0, 0, 0);
      tick(); expect_cycle("r5", 0, 0, 1, 32'h108, 1, 32'h100);
      tick(); expect_cycle("r6", 1, 32'h108, 0, 0, 1, 32'h104);
      // redirect coinciding with a response and a pop
      tick(); expect_cycle("c0", 1, 32'h10C, 0, 0, 0, 0);
      tick(); redirect_valid = 1'b1; redirect_pc = 32'h200;
      expect_cycle("c1", 0, 0, 1, 32'h200, 1, 32'h108);
      chk("c1.rvalid", 32'(imem_rvalid), 32'd1);
      tick(); redirect_valid = 1'b0; expect_cycle("c2", 1, 32'h200, 0, 0, 0, 0);
      chk("c2.fifo_cnt", 32'(dut.fifo_cnt), 32'd0);
      chk("c2.discard", 32'(dut.discard), 32'd0);
      chk("c2.outst", 32'(dut.outst), 32'd0);
      tick(); expect_cycle("c3", 1, 32'h204, 0, 0, 0, 0);
      tick(); expect_cycle("c4", 0, 0, 1, 32'h208, 1, 32'h200);
      // asynchronous reset between edges
      #1; reset = 1'b0;
      expect_cycle("ar", 0, 0, 0, 0, 0, 0);
      chk("ar.newPC", newPC, 32'h0);
      chk("ar.fifo_cnt", 32'(dut.fifo_cnt), 32'd0);
      chk("ar.outst", 32'(dut.outst), 32'd0);
      chk("ar.discard", 32'(dut.discard), 32'd0);
      tick(); tick();
      reset = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h102;
`ifdef FETCH_MISALIGN_CHECK_EN
      expect_cycle("m0", 0, 0, 1, 32'h100, 0, 0);
      chk("m0.misalign_err", 32'(misalign_err), 32'd0);
      tick(); redirect_valid = 1'b0;
      expect_cycle("m1", 1, 32'h100, 0, 0, 0, 0);
      chk("m1.misalign_err", 32'(misalign_err), 32'd1);
      tick(); #1;
      chk("m2.misalign_err", 32'(misalign_err), 32'd0);
`else
      expect_cycle("m0", 0, 0, 1, 32'h102, 0, 0);
      tick(); redirect_valid = 1'b0;
      expect_cycle("m1", 1, 32'h102, 0, 0, 0, 0);
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
